// File: rtl/cnn_core_div_pkg.sv
// Shared constants and FSM state encoding for the cnn_core sequential
// signed-by-unsigned divider.
package cnn_core_div_pkg;

    localparam int DIV_DIN0_W = 22;
    localparam int DIV_DIN1_W = 6;
    localparam int DIV_DOUT_W = 16;
    localparam int DIV_LAT    = 24;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_e;

endpackage

// File: rtl/cnn_core_sdiv_22s_6ns_16_seq_div_u.sv
// Unsigned restoring shift-subtract core: one quotient bit per enabled step,
// magnitudes in, quotient/remainder magnitudes out.
module cnn_core_sdiv_22s_6ns_16_seq_div_u
    import cnn_core_div_pkg::*;
#(
    parameter int W0 = DIV_DIN0_W,
    parameter int W1 = DIV_DIN1_W,
    parameter int WQ = DIV_DOUT_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ce_i,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [W0-1:0] dividend_i,
    input  logic [W1-1:0] divisor_i,
    output logic [WQ-1:0] quot_o,
    output logic [W1-1:0] rem_o
);

    logic [W0-1:0] quot_q;
    logic [W1-1:0] rem_q;
    logic [W1-1:0] div_q;
    logic [W1:0]   trial;
    logic [W1-1:0] diff;
    logic          ge;

    // The remainder always stays below the divisor, so the subtraction
    // is exact in W1 bits whenever the trial value is large enough.
    always_comb begin
        trial = {rem_q, quot_q[W0-1]};
        ge    = trial >= {1'b0, div_q};
        diff  = trial[W1-1:0] - div_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            quot_q <= '0;
            rem_q  <= '0;
            div_q  <= '0;
        end else if (ce_i) begin
            if (load_i) begin
                quot_q <= dividend_i;
                rem_q  <= '0;
                div_q  <= divisor_i;
            end else if (step_i) begin
                quot_q <= {quot_q[W0-2:0], ge};
                rem_q  <= ge ? diff : trial[W1-1:0];
            end
        end
    end

    assign quot_o = quot_q[WQ-1:0];
    assign rem_o  = rem_q;

endmodule

// File: rtl/cnn_core_sdiv_22s_6ns_16_seq.sv
// Sequential 22s / 6ns -> 16s divider with start/done handshake; handles
// sign extraction/restoration, divide-by-zero and the result registers.
module cnn_core_sdiv_22s_6ns_16_seq
    import cnn_core_div_pkg::*;
#(
    parameter int NUM_STAGE  = DIV_LAT,
    parameter int din0_WIDTH = DIV_DIN0_W,
    parameter int din1_WIDTH = DIV_DIN1_W,
    parameter int dout_WIDTH = DIV_DOUT_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  start,
    output logic                  ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH:0]   rem,
    output logic                  div_zero
);

    localparam int CNT_W = $clog2(NUM_STAGE);

    div_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    load, step;
    logic                    neg_q, dz_q;
    logic [din0_WIDTH-1:0]   absDin0;
    logic [dout_WIDTH-1:0]   quotMag, quotS_q;
    logic [din1_WIDTH-1:0]   remMag;
    logic [din1_WIDTH:0]     remS_q;
    logic                    done_q, divZero_q;
    logic [dout_WIDTH-1:0]   dout_q;
    logic [din1_WIDTH:0]     rem_q;

    // -2^21 negates to 2^21, which is still correct read as unsigned.
    assign absDin0 = din0[din0_WIDTH-1] ? (-din0) : din0;

    cnn_core_sdiv_22s_6ns_16_seq_div_u #(
        .W0(din0_WIDTH),
        .W1(din1_WIDTH),
        .WQ(dout_WIDTH)
    ) u_div (
        .clk_i     (ap_clk),
        .rst_i     (ap_rst),
        .ce_i      (ce),
        .load_i    (load),
        .step_i    (step),
        .dividend_i(absDin0),
        .divisor_i (din1),
        .quot_o    (quotMag),
        .rem_o     (remMag)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = CNT_W'(din0_WIDTH - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            dz_q      <= 1'b0;
            quotS_q   <= '0;
            remS_q    <= '0;
            done_q    <= 1'b0;
            dout_q    <= '0;
            rem_q     <= '0;
            divZero_q <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= 1'b0;
            if (load) begin
                neg_q <= din0[din0_WIDTH-1];
                dz_q  <= (din1 == '0);
            end
            // Truncation toward zero: both quotient and remainder follow the dividend sign.
            if (state_q == FIX) begin
                quotS_q <= neg_q ? (-quotMag) : quotMag;
                remS_q  <= neg_q ? (-{1'b0, remMag}) : {1'b0, remMag};
            end
            if (state_q == DONE) begin
                done_q    <= 1'b1;
                divZero_q <= dz_q;
                if (dz_q) begin
                    dout_q <= neg_q ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                                    : {1'b0, {(dout_WIDTH-1){1'b1}}};
                    rem_q  <= '0;
                end else begin
                    dout_q <= quotS_q;
                    rem_q  <= remS_q;
                end
            end
        end
    end

    assign ready    = (state_q == IDLE);
    assign done     = done_q;
    assign dout     = dout_q;
    assign rem      = rem_q;
    assign div_zero = divZero_q;

endmodule
